// File: rtl/sat_accum_adder.sv
// Registered add/sub/accumulate/clear unit with optional unsigned saturation.
// Results queue in a small output FIFO so downstream stalls never drop data.
module sat_accum_adder #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          SATURATE   = 1'b1,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_a,
   input  logic [WIDTH-1:0]              in_b,
   input  logic [1:0]                    in_mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_flag,
   output logic [WIDTH-1:0]              acc_value,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_ACC = 2'b10,
      MODE_CLR = 2'b11
   } mode_e;

   mode_e              mode_c;
   logic [WIDTH:0]     raw_c;
   logic               flag_c;
   logic [WIDTH-1:0]   res_c;
   logic               accept_c;
   logic               pop_c;

   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] flag_mem;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   assign mode_c   = mode_e'(in_mode);
   assign accept_c = in_valid && in_ready;
   assign pop_c    = out_valid && out_ready;

   // Arithmetic at WIDTH+1 bits; the carry/borrow drives flag and clamping
   always_comb begin
      raw_c  = '0;
      flag_c = 1'b0;
      res_c  = '0;
      case (mode_c)
         MODE_ADD: begin
            raw_c  = {1'b0, in_a} + {1'b0, in_b};
            flag_c = raw_c[WIDTH];
            res_c  = (SATURATE && flag_c) ? '1 : raw_c[WIDTH-1:0];
         end
         MODE_SUB: begin
            raw_c  = {1'b0, in_a} - {1'b0, in_b};
            flag_c = (in_a < in_b);
            res_c  = (SATURATE && flag_c) ? '0 : raw_c[WIDTH-1:0];
         end
         MODE_ACC: begin
            raw_c  = {1'b0, acc_q} + {1'b0, in_a};
            flag_c = raw_c[WIDTH];
            res_c  = (SATURATE && flag_c) ? '1 : raw_c[WIDTH-1:0];
         end
         default: begin
            raw_c  = '0;
            flag_c = 1'b0;
            res_c  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         acc_q    <= '0;
         flag_mem <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            data_mem[i] <= '0;
         end
      end else begin
         if (accept_c) begin
            data_mem[wr_ptr] <= res_c;
            flag_mem[wr_ptr] <= flag_c;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({accept_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // Only accepted ACC/CLR operations touch the accumulator
         if (accept_c && (mode_c == MODE_ACC)) begin
            acc_q <= res_c;
         end else if (accept_c && (mode_c == MODE_CLR)) begin
            acc_q <= '0;
         end
      end
   end

   assign in_ready   = (count != CNT_W'(FIFO_DEPTH));
   assign out_valid  = (count != '0);
   assign out_data   = out_valid ? data_mem[rd_ptr] : '0;
   assign out_flag   = out_valid ? flag_mem[rd_ptr] : 1'b0;
   assign acc_value  = acc_q;
   assign fifo_count = count;

endmodule
